// File: rtl/guess_pkg.sv
// Shared types, constants and helpers for the guessing-round controller.
package guess_pkg;

    typedef enum logic [1:0] {
        GEN,
        WAIT,
        CHECK,
        HOLD
    } round_state_t;

    localparam logic [1:0] HINT_NONE = 2'b00;
    localparam logic [1:0] HINT_LOW  = 2'b01;
    localparam logic [1:0] HINT_HIGH = 2'b10;
    localparam logic [1:0] HINT_HIT  = 2'b11;

    localparam int unsigned TIME_PER_DIGIT = 30;

    // Exclusive upper bound of the secret number; 0 digits behaves as 1
    function automatic logic [9:0] digit_limit(input logic [1:0] max_digit);
        logic [9:0] lim;
        case (max_digit)
            2'd2:    lim = 10'd100;
            2'd3:    lim = 10'd1000;
            default: lim = 10'd10;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/guess_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the target source.
module guess_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        restart,
    output logic [15:0] state
);

    // Shift left every cycle, feeding back the XOR of the tap bits
    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            state <= SEED;
        end else begin
            state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
        end
    end

endmodule

// File: rtl/guess_round_ctrl.sv
// Guessing-round sequencer: target generation, per-round countdown, guess evaluation.
// Optional feature macro: GUESS_HINT_EN (drives too-low / too-high / correct hints;
// without it hint stays 00 and CHECK only tests equality).
module guess_round_ctrl
    import guess_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       restart,
    input  logic       confirmButton,
    input  logic [9:0] guess_value,
    input  logic [1:0] max_digit,
    input  logic       game_active,
    output logic [3:0] round,
    output logic [2:0] incorrect_guesses,
    output logic [6:0] timer,
    output logic [9:0] target,
    output logic [1:0] hint
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    round_state_t  state;
    logic [PW-1:0] presc;
    logic [9:0]    guess_q;
    logic [15:0]   lfsr;
    logic          unused_lfsr_hi;

    logic          sync1, sync2, sync2_d, confirm_pulse;

    logic [1:0]    eff_digits;
    logic [9:0]    limit;
    logic [9:0]    candidate;

    guess_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .restart (restart),
        .state   (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[15:10];
    assign eff_digits     = (max_digit == 2'd0) ? 2'd1 : max_digit;
    assign limit          = digit_limit(max_digit);

    // Candidate width tracks the digit count so rejection sampling rarely loops
    always_comb begin
        candidate = '0;
        case (eff_digits)
            2'd1:    candidate = {6'd0, lfsr[3:0]};
            2'd2:    candidate = {3'd0, lfsr[6:0]};
            default: candidate = lfsr[9:0];
        endcase
    end

    // Two-flop synchroniser plus rising-edge detect -> registered 1-cycle confirm pulse
    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            sync2_d       <= 1'b0;
            confirm_pulse <= 1'b0;
        end else begin
            sync1         <= confirmButton;
            sync2         <= sync1;
            sync2_d       <= sync2;
            confirm_pulse <= sync2 & ~sync2_d;
        end
    end

`ifndef GUESS_HINT_EN
    assign hint = HINT_NONE;
`endif

    // Round FSM with timer/prescaler and scoring registers; everything freezes when inactive
    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            state             <= GEN;
            round             <= '0;
            incorrect_guesses <= '0;
            timer             <= 7'(TIME_PER_DIGIT);
            target            <= '0;
            presc             <= '0;
            guess_q           <= '0;
`ifdef GUESS_HINT_EN
            hint              <= HINT_NONE;
`endif
        end else if (game_active) begin
            case (state)
                GEN: begin
                    if (candidate < limit) begin
                        target            <= candidate;
                        timer             <= 7'(TIME_PER_DIGIT * eff_digits);
                        incorrect_guesses <= '0;
                        presc             <= '0;
                        state             <= WAIT;
`ifdef GUESS_HINT_EN
                        hint              <= HINT_NONE;
`endif
                    end
                end
                WAIT, CHECK: begin
                    // Tick and guess evaluation are independent; both may land in one cycle
                    if (presc == PRESC_MAX) begin
                        presc <= '0;
                        if (timer != '0) begin
                            timer <= timer - 7'd1;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                    if (state == WAIT) begin
                        if (confirm_pulse && (timer != '0)) begin
                            guess_q <= guess_value;
                            state   <= CHECK;
                        end
                    end else if (guess_q == target) begin
                        if (round != 4'd15) begin
                            round <= round + 4'd1;
                        end
`ifdef GUESS_HINT_EN
                        hint  <= HINT_HIT;
`endif
                        state <= HOLD;
                    end else begin
                        if (incorrect_guesses != 3'd7) begin
                            incorrect_guesses <= incorrect_guesses + 3'd1;
                        end
`ifdef GUESS_HINT_EN
                        hint  <= (guess_q < target) ? HINT_LOW : HINT_HIGH;
`endif
                        state <= WAIT;
                    end
                end
                HOLD: begin
                    state <= GEN;
                end
                default: begin
                    state <= GEN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Self-checking bench for guess_round_ctrl with a cycle-level behavioural model.
module tb_guess_round_ctrl;

    localparam int TD = 4;
`ifdef GUESS_HINT_EN
    localparam bit HINT_ON = 1'b1;
`else
    localparam bit HINT_ON = 1'b0;
`endif

    // Model phases
    localparam int PH_GEN   = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_CHECK = 2;
    localparam int PH_HOLD  = 3;

    logic       clk = 1'b0;
    logic       restart = 1'b1;
    logic       confirmButton = 1'b0;
    logic [9:0] guess_value = '0;
    logic [1:0] max_digit = 2'd1;
    logic       game_active = 1'b1;
    logic [3:0] round;
    logic [2:0] incorrect_guesses;
    logic [6:0] timer;
    logic [9:0] target;
    logic [1:0] dut_hint;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    guess_round_ctrl #(
        .TICK_DIV  (TD),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk               (clk),
        .restart           (restart),
        .confirmButton     (confirmButton),
        .guess_value       (guess_value),
        .max_digit         (max_digit),
        .game_active       (game_active),
        .round             (round),
        .incorrect_guesses (incorrect_guesses),
        .timer             (timer),
        .target            (target),
        .hint              (dut_hint)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_phase, m_round, m_inc, m_timer, m_target, m_hint, m_presc, m_guess;
    logic [15:0] m_lfsr;
    bit          h [5];
    int          md, lim, cand, t_old;
    bit          conf, tick;

    always @(posedge clk or negedge restart) begin
        if (!restart) begin
            m_phase = PH_GEN; m_round = 0; m_inc = 0; m_timer = 30; m_target = 0;
            m_hint = 0; m_presc = 0; m_guess = 0; m_lfsr = 16'hACE1;
            for (int i = 0; i < 5; i++) h[i] = 1'b0;
        end else begin
            md   = (max_digit == 0) ? 1 : int'(max_digit);
            lim  = (md == 1) ? 10 : (md == 2) ? 100 : 1000;
            cand = int'(m_lfsr) % ((md == 1) ? 16 : (md == 2) ? 128 : 1024);
            // button sampled 3 edges ago high, 4 edges ago low
            conf = h[2] && !h[3];
            if (game_active) begin
                if (m_phase == PH_GEN) begin
                    if (cand < lim) begin
                        m_target = cand; m_timer = 30 * md; m_inc = 0; m_hint = 0;
                        m_presc = 0; m_phase = PH_WAIT;
                    end
                end else if (m_phase == PH_HOLD) begin
                    m_phase = PH_GEN;
                end else begin
                    t_old   = m_timer;
                    tick    = (m_presc == TD - 1);
                    m_presc = tick ? 0 : m_presc + 1;
                    if (tick && m_timer > 0) m_timer = m_timer - 1;
                    if (m_phase == PH_WAIT) begin
                        if (conf && t_old != 0) begin
                            m_guess = int'(guess_value);
                            m_phase = PH_CHECK;
                        end
                    end else if (m_guess == m_target) begin
                        m_hint  = 3;
                        if (m_round < 15) m_round = m_round + 1;
                        m_phase = PH_HOLD;
                    end else begin
                        if (m_inc < 7) m_inc = m_inc + 1;
                        m_hint  = (m_guess < m_target) ? 1 : 2;
                        m_phase = PH_WAIT;
                    end
                end
            end
            for (int i = 4; i > 0; i--) h[i] = h[i-1];
            h[0]   = confirmButton;
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("round", int'(round), m_round);
            chk("incorrect_guesses", int'(incorrect_guesses), m_inc);
            chk("timer", int'(timer), m_timer);
            chk("target", int'(target), m_target);
            chk("hint", int'(dut_hint), HINT_ON ? m_hint : 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input int g);
        guess_value   = 10'(g);
        confirmButton = 1'b1;
        @(negedge clk);
        @(negedge clk);
        confirmButton = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_for_wait(input string name);
        int n;
        n = 0;
        while (m_phase != PH_WAIT && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (m_phase != PH_WAIT) chk({name, "_wait_timeout"}, 0, 1);
    endtask

    int saved_round, saved_inc, saved_timer, wrong_cnt, iter;
    bit seen10;

    initial begin
        // Reset, then release away from the clock edge
        #2 restart = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_round", int'(round), 0);
        chk("rst_timer", int'(timer), 30);
        chk("rst_target", int'(target), 0);
        chk("rst_hint", int'(dut_hint), 0);
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        // Seed low nibble 1 is accepted on the first edge; model LFSR steps once
        chk("model_lfsr_step", int'(m_lfsr), 16'h59C3);
        chk("t1_target", int'(target), 1);
        chk("t1_timer", int'(timer), 30);
        chk("t1_round", int'(round), 0);
        chk("t1_hint", int'(dut_hint), 0);

        // Low, high, then correct guess against target 1
        press(m_target - 1);
        chk("t2_inc1", int'(incorrect_guesses), 1);
        chk("t2_hint_low", int'(dut_hint), HINT_ON ? 1 : 0);
        press(m_target + 1);
        chk("t2_inc2", int'(incorrect_guesses), 2);
        chk("t2_hint_high", int'(dut_hint), HINT_ON ? 2 : 0);
        press(m_target);
        chk("t2_round1", int'(round), 1);
        wait_for_wait("t2");
        chk("t2_inc_cleared", int'(incorrect_guesses), 0);

        // Random rounds up to and past round saturation
        seen10 = 1'b0;
        iter = 0;
        while ((m_round < 15 || iter < 20) && iter < 120) begin
            iter++;
            max_digit = 2'($urandom_range(0, 3));
            wait_for_wait("t6");
            wrong_cnt = 0;
            while (wrong_cnt < 3 && $urandom_range(0, 9) < 4) begin
                case ($urandom_range(0, 2))
                    0: press(m_target - 1);
                    1: press(m_target + 1);
                    default: press(int'($urandom_range(0, 1023)) == m_target ? m_target + 2 : int'($urandom_range(0, 1023)));
                endcase
                wrong_cnt++;
            end
            press(m_target);
            if (m_round == 10 && !seen10) begin
                seen10 = 1'b1;
                chk("t6_round10", int'(round), 10);
            end
        end
        chk("t6_round_sat", int'(round), 15);

        // Three digits: reload 90 and out-of-range guess is wrong
        max_digit = 2'd3;
        wait_for_wait("t4a");
        press(m_target);
        wait_for_wait("t4b");
        chk("t4_timer90", int'(timer), 90);
        chk("t4_target_range", int'(target <= 10'd999), 1);
        saved_inc = m_inc;
        press(1023);
        chk("t4_hint_high", int'(dut_hint), HINT_ON ? 2 : 0);
        chk("t4_inc", int'(incorrect_guesses), saved_inc + 1);

        // Freeze with confirms applied while inactive
        wait_for_wait("t5");
        saved_round = m_round;
        saved_inc   = m_inc;
        saved_timer = m_timer;
        game_active = 1'b0;
        press(m_target);
        press(m_target);
        repeat (4) @(negedge clk);
        chk("t5_frozen_timer", int'(timer), saved_timer);
        chk("t5_frozen_round", int'(round), saved_round);
        chk("t5_frozen_inc", int'(incorrect_guesses), saved_inc);
        game_active = 1'b1;

        // Asynchronous reset while in CHECK
        guess_value   = 10'(m_target + 1);
        confirmButton = 1'b1;
        iter = 0;
        while (m_phase != PH_CHECK && iter < 12) begin
            @(negedge clk);
            iter++;
        end
        if (m_phase != PH_CHECK) chk("t5_check_timeout", 0, 1);
        #2 restart = 1'b0;
        #1;
        chk("t5_rst_round", int'(round), 0);
        chk("t5_rst_inc", int'(incorrect_guesses), 0);
        chk("t5_rst_timer", int'(timer), 30);
        chk("t5_rst_target", int'(target), 0);
        chk("t5_rst_hint", int'(dut_hint), 0);
        confirmButton = 1'b0;
        max_digit = 2'd1;
        @(negedge clk);
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        chk("t5_reseed_target", int'(target), 1);

        // Timer expiry: holds at 0 and a correct guess no longer scores
        repeat (30 * TD + 10) @(negedge clk);
        chk("t3_timer_zero", int'(timer), 0);
        saved_round = m_round;
        press(m_target);
        repeat (TD * 2) @(negedge clk);
        chk("t3_round_unchanged", int'(round), saved_round);
        chk("t3_timer_hold", int'(timer), 0);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
